// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage core: memory freeze, multi-cycle
// multiply hold, load-use bubble and deferred IF/ID flush on taken branches.
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             idex_memread,
    input  logic             ex_mul,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_bubble,
    output logic             ifid_flush,
    output logic             mem_err,
    output logic [1:0]       ctrl_state
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_MUL_WAIT = 2'd2
    } state_t;

    localparam int MUL_W = $clog2(MUL_CYCLES);
    localparam logic [MUL_W-1:0] MUL_LOAD = MUL_W'(MUL_CYCLES - 1);
    localparam logic [MUL_W-1:0] MUL_ONE  = MUL_W'(1);
    localparam logic [7:0]       MEM_LIM  = 8'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    logic [MUL_W-1:0] mul_cnt, mul_cnt_nxt;
    logic [7:0]       mem_cnt, mem_cnt_nxt;
    logic             flush_pend, flush_pend_nxt;

    logic freeze;
    logic load_use;
    logic in_mul;
    logic flush_req;
    logic err_set;

    assign freeze    = (exmem_memread | exmem_memwrite) & ~dmem_ready;
    assign load_use  = idex_memread & (idex_rt != '0) &
                       ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    assign in_mul    = (state == S_MUL_WAIT);
    assign flush_req = branch_taken | flush_pend;

    // Saturating freeze-length counter; the timeout flag is sticky until reset.
    assign mem_cnt_nxt = freeze ? ((mem_cnt == 8'hFF) ? mem_cnt : mem_cnt + 8'd1) : 8'd0;
    assign err_set     = freeze & (mem_cnt_nxt == MEM_LIM);

    assign ctrl_state = state;

    always_comb begin
        // NOTE: every output and next-state term gets a default first so no latches are inferred.
        stall          = 1'b0;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        idex_write     = 1'b1;
        exmem_bubble   = 1'b0;
        ifid_flush     = 1'b0;
        state_nxt      = state;
        mul_cnt_nxt    = mul_cnt;
        flush_pend_nxt = flush_pend;

        if (rst) begin
            stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end else if (freeze) begin
            // Whole pipeline frozen; a multiply keeps its state and count.
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            idex_write     = 1'b0;
            state_nxt      = in_mul ? S_MUL_WAIT : S_MEM_WAIT;
            flush_pend_nxt = flush_req;
        end else if (in_mul) begin
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            flush_pend_nxt = flush_req;
            if (mul_cnt == MUL_ONE) begin
                // Last EX cycle: let the product move on to MEM.
                idex_write  = 1'b1;
                state_nxt   = S_RUN;
                mul_cnt_nxt = '0;
            end else begin
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                mul_cnt_nxt  = mul_cnt - MUL_ONE;
            end
        end else if (ex_mul) begin
            // First EX cycle of the multiply counts toward MUL_CYCLES.
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            idex_write     = 1'b0;
            exmem_bubble   = 1'b1;
            state_nxt      = S_MUL_WAIT;
            mul_cnt_nxt    = MUL_LOAD;
            flush_pend_nxt = flush_req;
        end else if (load_use) begin
            stall          = 1'b1;
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            state_nxt      = S_RUN;
            flush_pend_nxt = flush_req;
        end else begin
            ifid_flush     = flush_req;
            state_nxt      = S_RUN;
            flush_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state      <= S_RUN;
            mul_cnt    <= '0;
            mem_cnt    <= '0;
            flush_pend <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            mul_cnt    <= mul_cnt_nxt;
            mem_cnt    <= mem_cnt_nxt;
            flush_pend <= flush_pend_nxt;
            mem_err    <= mem_err | err_set;
        end
    end

endmodule
